// File: rtl/exception_epc_stack_if.sv
// Bus between the control FSM and the exception capture unit.
// The control side drives requests, the PC, acknowledge and eret.
// The unit returns the stack top, the occupancy and the status flags.
interface exception_epc_stack_if #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 3
);
  localparam int CAUSE_W = $clog2(NUM_SRC + 1);
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [NUM_SRC-1:0] exc_req;
  logic [DATA_W-1:0]  pc_in;
  logic               exc_ack;
  logic               eret;
  logic [DATA_W-1:0]  epc_out;
  logic [CAUSE_W-1:0] cause_out;
  logic               exc_pending;
  logic               in_handler;
  logic [CNT_W-1:0]   depth_out;
  logic               fatal;

  modport master (
    output exc_req, pc_in, exc_ack, eret,
    input  epc_out, cause_out, exc_pending, in_handler, depth_out, fatal
  );

  modport slave (
    input  exc_req, pc_in, exc_ack, eret,
    output epc_out, cause_out, exc_pending, in_handler, depth_out, fatal
  );
endinterface

// File: rtl/exception_epc_stack.sv
// Exception capture unit with a nested EPC/cause stack.
// Prioritises the request lines (bit 0 wins) and pushes {pc, cause}.
// It holds exc_pending until acknowledged and pops on eret.
// Optional macro EXC_STACK_TRAP_EN: a push into a full stack enters a sticky
// FATAL state. Without it, the stack is a ring and a push at full overwrites
// the oldest entry.
module exception_epc_stack #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int NUM_SRC = 3
) (
  input logic                   clk,
  input logic                   reset,
  exception_epc_stack_if.slave  bus
);
  localparam int CAUSE_W = $clog2(NUM_SRC + 1);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = $clog2(DEPTH);

`ifdef EXC_STACK_TRAP_EN
  typedef enum logic [1:0] {IDLE, PENDING, FATAL} state_t;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   depth_q;
  logic [DATA_W-1:0]  epc_mem   [DEPTH];
  logic [CAUSE_W-1:0] cause_mem [DEPTH];
  logic               push, pop, full;
  logic [PTR_W-1:0]   top_idx;

  // Lowest set request bit wins; cause is its index + 1, 0 when idle.
  function automatic logic [CAUSE_W-1:0] prio_cause(input logic [NUM_SRC-1:0] req);
    logic [CAUSE_W-1:0] c;
    c = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) c = CAUSE_W'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign full    = (depth_q == CNT_W'(DEPTH));
  assign top_idx = ptr_dec(wr_ptr_q);

  // Next state and push/pop decisions; exception beats eret in IDLE.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.exc_req) begin
`ifdef EXC_STACK_TRAP_EN
          if (full) begin
            state_d = FATAL;
          end else begin
            push    = 1'b1;
            state_d = PENDING;
          end
`else
          push    = 1'b1;
          state_d = PENDING;
`endif
        end else if (bus.eret && (depth_q != '0)) begin
          pop = 1'b1;
        end
      end
      PENDING: begin
        if (bus.exc_ack) state_d = IDLE;
      end
`ifdef EXC_STACK_TRAP_EN
      FATAL: state_d = FATAL;
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, write pointer and occupancy; a push at full keeps depth at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      depth_q  <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (!full) depth_q <= depth_q + 1'b1;
      end else if (pop) begin
        wr_ptr_q <= ptr_dec(wr_ptr_q);
        depth_q  <= depth_q - 1'b1;
      end
    end
  end

  // Stack storage; at full, the write slot is the oldest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        epc_mem[i]   <= '0;
        cause_mem[i] <= '0;
      end
    end else if (push) begin
      epc_mem[wr_ptr_q]   <= bus.pc_in;
      cause_mem[wr_ptr_q] <= prio_cause(bus.exc_req);
    end
  end

  assign bus.epc_out     = (depth_q != '0) ? epc_mem[top_idx]   : '0;
  assign bus.cause_out   = (depth_q != '0) ? cause_mem[top_idx] : '0;
  assign bus.depth_out   = depth_q;
  assign bus.in_handler  = (depth_q != '0);
  assign bus.exc_pending = (state_q == PENDING);
`ifdef EXC_STACK_TRAP_EN
  assign bus.fatal       = (state_q == FATAL);
`else
  assign bus.fatal       = 1'b0;
`endif
endmodule

// File: tb/tb_exception_epc_stack.sv
// Bench for exception_epc_stack (DATA_W=32, DEPTH=4, NUM_SRC=3).
// A table of cycle vectors feeds a scoreboard queue of expected outputs.
// Hand-written sequences cover async reset and the full-stack behaviour.
module tb_exception_epc_stack;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  exception_epc_stack_if #(.DATA_W(32), .DEPTH(4), .NUM_SRC(3)) bus ();

  exception_epc_stack #(.DATA_W(32), .DEPTH(4), .NUM_SRC(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] pc;
    logic        ack;
    logic        eret;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [2:0]  depth;
    logic        pend;
    logic        inh;
    logic        fat;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(logic [2:0] r, logic [31:0] pc, logic a, logic e,
                              logic [31:0] epc, logic [1:0] c, logic [2:0] d,
                              logic p, logic f);
    vec_t v;
    v.req = r; v.pc = pc; v.ack = a; v.eret = e;
    v.epc = epc; v.cause = c; v.depth = d; v.pend = p;
    v.inh = (d != 3'd0); v.fat = f;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(string tag, vec_t e);
    chk({tag, ".epc"},   bus.epc_out,            e.epc);
    chk({tag, ".cause"}, 32'(bus.cause_out),     32'(e.cause));
    chk({tag, ".depth"}, 32'(bus.depth_out),     32'(e.depth));
    chk({tag, ".pend"},  32'(bus.exc_pending),   32'(e.pend));
    chk({tag, ".inh"},   32'(bus.in_handler),    32'(e.inh));
    chk({tag, ".fatal"}, 32'(bus.fatal),         32'(e.fat));
  endtask

  // Drive one cycle of inputs at the falling edge, check after the next rise.
  task automatic run_vec(string tag, vec_t v);
    vec_t e;
    bus.exc_req = v.req;
    bus.pc_in   = v.pc;
    bus.exc_ack = v.ack;
    bus.eret    = v.eret;
    exp_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_outs(tag, e);
  endtask

  task automatic idle_inputs();
    bus.exc_req = '0;
    bus.pc_in   = '0;
    bus.exc_ack = 1'b0;
    bus.eret    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    n_chk = 0;
    n_err = 0;
    z = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_inputs();
    reset = 1'b1;

    // Table: r, pc, ack, eret -> epc, cause, depth, pend, fatal
    tbl.push_back(mk(3'b000, 32'h0,   0, 0, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(3'b110, 32'h40,  0, 0, 32'h40,  2, 1, 1, 0));
    tbl.push_back(mk(3'b111, 32'h99,  0, 1, 32'h40,  2, 1, 1, 0));
    tbl.push_back(mk(3'b000, 32'h0,   1, 0, 32'h40,  2, 1, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   1, 0, 32'h40,  2, 1, 0, 0));
    tbl.push_back(mk(3'b010, 32'h20,  0, 1, 32'h20,  2, 2, 1, 0));
    tbl.push_back(mk(3'b000, 32'h0,   1, 0, 32'h20,  2, 2, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h40,  2, 1, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(3'b100, 32'h10,  0, 0, 32'h10,  3, 1, 1, 0));
    tbl.push_back(mk(3'b000, 32'h0,   1, 0, 32'h10,  3, 1, 0, 0));
    tbl.push_back(mk(3'b001, 32'h80,  0, 0, 32'h80,  1, 2, 1, 0));
    tbl.push_back(mk(3'b000, 32'h0,   1, 0, 32'h80,  1, 2, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h10,  3, 1, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(3'b010, 32'h100, 0, 0, 32'h100, 2, 1, 1, 0));
    tbl.push_back(mk(3'b100, 32'h200, 1, 0, 32'h100, 2, 1, 0, 0));
    tbl.push_back(mk(3'b100, 32'h200, 0, 0, 32'h200, 3, 2, 1, 0));
    tbl.push_back(mk(3'b000, 32'h0,   1, 0, 32'h200, 3, 2, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h100, 2, 1, 0, 0));
    tbl.push_back(mk(3'b000, 32'h0,   0, 1, 32'h0,   0, 0, 0, 0));

    // Reset state while reset is held
    #3;
    check_outs("reset", z);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Async reset mid-PENDING at depth 2, checked before any clock edge
    run_vec("rst_a", mk(3'b001, 32'h10, 0, 0, 32'h10, 1, 1, 1, 0));
    run_vec("rst_b", mk(3'b000, 32'h0,  1, 0, 32'h10, 1, 1, 0, 0));
    run_vec("rst_c", mk(3'b010, 32'h20, 0, 0, 32'h20, 2, 2, 1, 0));
    idle_inputs();
    #2 reset = 1'b1;
    #1 check_outs("async_rst", z);
    @(negedge clk);
    reset = 1'b0;
    run_vec("post_rst", z);

    // Fill the stack with PCs 1..4
    for (int k = 1; k <= 4; k++) begin
      run_vec($sformatf("fill%0d", k), mk(3'b010, 32'(k), 0, 0, 32'(k), 2, 3'(k), 1, 0));
      run_vec($sformatf("fack%0d", k), mk(3'b000, 32'h0,  1, 0, 32'(k), 2, 3'(k), 0, 0));
    end

`ifdef EXC_STACK_TRAP_EN
    run_vec("trap",      mk(3'b001, 32'hFC, 0, 0, 32'h4, 2, 4, 0, 1));
    run_vec("trap_eret", mk(3'b000, 32'h0,  0, 1, 32'h4, 2, 4, 0, 1));
    run_vec("trap_ack",  mk(3'b000, 32'h0,  1, 0, 32'h4, 2, 4, 0, 1));
    run_vec("trap_req",  mk(3'b100, 32'h77, 0, 1, 32'h4, 2, 4, 0, 1));
    idle_inputs();
    reset = 1'b1;
    #1 check_outs("trap_rst", z);
    @(negedge clk);
    reset = 1'b0;
`else
    run_vec("ring",      mk(3'b001, 32'h5, 0, 0, 32'h5, 1, 4, 1, 0));
    run_vec("ring_ack",  mk(3'b000, 32'h0, 1, 0, 32'h5, 1, 4, 0, 0));
    run_vec("ring_pop1", mk(3'b000, 32'h0, 0, 1, 32'h4, 2, 3, 0, 0));
    run_vec("ring_pop2", mk(3'b000, 32'h0, 0, 1, 32'h3, 2, 2, 0, 0));
    run_vec("ring_pop3", mk(3'b000, 32'h0, 0, 1, 32'h2, 2, 1, 0, 0));
    run_vec("ring_pop4", mk(3'b000, 32'h0, 0, 1, 32'h0, 0, 0, 0, 0));
`endif

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/exception_epc_stack.md
# exception_epc_stack

Parametrised exception capture unit; it succeeds the single 32-bit EPC register. It does three things:
- prioritises several exception sources;
- pushes the faulting PC together with a cause code onto a small EPC stack, which supports nested exceptions;
- holds a pending flag until the control unit acknowledges the vector.

It sits beside the PC and control FSM. The control FSM returns from the handler with `eret`, which pops the stack.

## Interface
Parameters:
- `DATA_W`, 32: PC/EPC width.
- `DEPTH`, 4: EPC stack entries (≥2).
- `NUM_SRC`, 3: exception request lines. Default mapping:
  - bit 0 = opcode inexistente;
  - bit 1 = overflow;
  - bit 2 = div0.

Derived widths:
- `CAUSE_W` = $clog2(NUM_SRC+1).
- `CNT_W` = $clog2(DEPTH+1).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `exc_req` in NUM_SRC: level exception requests; bit 0 has highest priority.
- `pc_in` in DATA_W: address of the current instruction.
- `exc_ack` in 1: control has vectored to the handler.
- `eret` in 1: return from exception; pops the stack.
- `epc_out` out DATA_W: PC at the stack top; 0 when the stack is empty.
- `cause_out` out CAUSE_W: cause at the stack top. Encoding is winning bit index + 1; 0 = none.
- `exc_pending` out 1: exception captured, not yet acknowledged.
- `in_handler` out 1: stack occupancy > 0.
- `depth_out` out CNT_W: current occupancy, 0..DEPTH.
- `fatal` out 1: sticky double-fault flag.

## Operation
States:
- **IDLE**
  - Any exc_req bit set → push {pc_in, cause}, occupancy +1, go to PENDING.
  - Cause = lowest set bit index + 1; all other simultaneous requests are discarded.
  - eret with occupancy > 0 and no exc_req → pop, occupancy −1.
  - eret with occupancy 0 → ignored, no state change.
  - eret together with exc_req → exception wins; the eret is discarded.
- **PENDING**
  - exc_pending = 1.
  - exc_req and eret are ignored.
  - exc_ack → IDLE.
- **FATAL** (exists only with EXC_STACK_TRAP_EN)
  - All inputs are ignored and the stack is frozen.
  - fatal = 1, exc_pending = 0.
  - Only reset exits this state.

Outputs:
- epc_out and cause_out always show the top entry. An empty stack drives both to 0.
- in_handler = (depth_out != 0).

Push when full: behaviour depends on the macro; see Configuration.

Reset (asynchronous, any state, mid-push or mid-pop):
- State → IDLE.
- All stack entries → 0.
- depth_out = 0, epc_out = 0, cause_out = 0.
- exc_pending = 0, in_handler = 0, fatal = 0.

## Timing
- Capture: exc_req and pc_in are sampled at edge N. epc_out, cause_out and depth_out update, and exc_pending rises, after edge N. One-cycle latency.
- PENDING lasts until exc_ack is sampled high. exc_ack at edge M clears exc_pending after M.
- The earliest next capture is at edge M+1.
- exc_ack sampled in IDLE is ignored.
- Pop: eret sampled at edge N. The new top and decremented depth are visible after N.
- Back-to-back capture → ack → capture → ack: no bubbles beyond the one PENDING cycle per exception.
- All outputs are registered or decoded from registers. There is no combinational path from inputs to outputs.

## Configuration
- Macro `EXC_STACK_TRAP_EN`.
- **Defined:**
  - A capture attempted at occupancy = DEPTH enters FATAL and sets fatal.
  - The stack contents and depth_out are unchanged.
  - exc_pending is not asserted.
- **Undefined:**
  - The stack behaves as a ring. A capture at occupancy = DEPTH overwrites the oldest entry.
  - The new entry becomes the top. depth_out stays at DEPTH.
  - State goes to PENDING as normal.
  - fatal is tied to 0 and the FATAL state is absent.

## Test plan
- **Reset:** assert reset mid-PENDING with depth 2 → all outputs 0 immediately, without waiting for a clock edge.
- **Priority:** exc_req=3'b110, pc_in=32'h40 → cause_out=2, epc_out=32'h40, depth_out=1, exc_pending=1 one cycle later. Then exc_ack → exc_pending=0.
- **Nesting:**
  - Capture div0 @32'h10, ack, then opcode @32'h80, ack → epc_out=32'h80, cause_out=1, depth_out=2.
  - eret → epc_out=32'h10, cause_out=3.
  - eret → epc_out=0, in_handler=0.
  - A third eret → no change.
- **Simultaneous events:**
  - In IDLE at depth 1: eret with exc_req=3'b010, pc_in=32'h20 → push wins; depth_out=2, cause_out=2.
  - In PENDING: exc_req and eret are ignored.
- **Full, macro defined:** fill DEPTH=4, then request @32'hFC → fatal=1, depth_out=4, top unchanged. Later eret and exc_ack have no effect until reset.
- **Full, macro undefined:** fill DEPTH=4 with PCs 1..4, then request @32'h5 → top=5, depth_out=4. Four erets return 4, 3, 2, then empty (0); entry 1 is lost.
